// File: rtl/afu_io_mc.sv
// Multi-channel CCI-P I/O adapter: round-robin read arbitration with mdata-based response
// routing, plus a single write/fence stream with outstanding-count and fence back-pressure.
module afu_io_mc #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 42,
    parameter int DATA_W      = 512,
    parameter int MAX_RD_OUT  = 64,
    parameter int MAX_WR_OUT  = 64,
    parameter int FENCE_BLOCK = 1
) (
    input  logic                     clk,
    input  logic                     spl_reset,
    input  logic [NUM_CH-1:0]        cor_rd_valid,
    input  logic [NUM_CH*ADDR_W-1:0] cor_rd_addr,
    output logic [NUM_CH-1:0]        cor_rd_ready,
    input  logic                     cor_wr_valid,
    input  logic                     cor_wr_fence,
    input  logic [ADDR_W-1:0]        cor_wr_addr,
    input  logic [DATA_W-1:0]        cor_wr_data,
    input  logic [15:0]              cor_wr_tag,
    output logic                     cor_wr_ready,
    input  logic                     c0_almfull,
    input  logic                     c1_almfull,
    output logic                     afu_tx_rd_valid,
    output logic [ADDR_W-1:0]        afu_tx_rd_addr,
    output logic [15:0]              afu_tx_rd_mdata,
    output logic                     afu_tx_wr_valid,
    output logic                     afu_tx_wr_fence,
    output logic [ADDR_W-1:0]        afu_tx_wr_addr,
    output logic [15:0]              afu_tx_wr_mdata,
    output logic [DATA_W-1:0]        afu_tx_data,
    input  logic                     spl_rx_rd_valid,
    input  logic [15:0]              spl_rx_rd_mdata,
    input  logic [DATA_W-1:0]        spl_rx_data,
    input  logic                     spl_rx_wr_valid,
    input  logic                     spl_rx_wr_fence,
    input  logic [15:0]              spl_rx_wr_mdata,
    output logic [NUM_CH-1:0]        io_rx_rd_valid,
    output logic [7:0]               io_rx_tag,
    output logic [DATA_W-1:0]        io_rx_data,
    output logic                     wr_rx_valid,
    output logic [15:0]              wr_rx_tag,
    output logic [9:0]               rd_out_cnt,
    output logic [9:0]               wr_out_cnt,
    output logic                     fence_pending,
    output logic                     err_unexp_rsp
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]   r_rr_ptr;
    logic [7:0]        r_seq [NUM_CH];
    logic [9:0]        r_rd_cnt;
    logic [9:0]        r_wr_cnt;
    logic              r_fence_pend;
    logic              r_err;
    logic              r_tx_rd_valid;
    logic [ADDR_W-1:0] r_tx_rd_addr;
    logic [15:0]       r_tx_rd_mdata;
    logic              r_tx_wr_valid;
    logic              r_tx_wr_fence;
    logic [ADDR_W-1:0] r_tx_wr_addr;
    logic [15:0]       r_tx_wr_mdata;
    logic [DATA_W-1:0] r_tx_data;
    logic [NUM_CH-1:0] r_rx_rd_valid;
    logic [7:0]        r_rx_tag;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_wr_rx_valid;
    logic [15:0]       r_wr_rx_tag;

    logic              w_rd_ok;
    logic              w_rd_found;
    logic              w_rd_acc;
    logic [CH_W-1:0]   w_idx;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [NUM_CH-1:0] w_gnt;
    logic [7:0]        w_rsp_ch;
    logic              w_rsp_ok;
    logic [NUM_CH-1:0] w_rsp_oh;
    logic              w_wr_rdy;
    logic              w_wr_acc;
    logic              w_wr_line;
    logic              w_wr_fnc;
    logic              w_wrsp_fnc;
    logic              w_wrsp_line;
    logic              w_wrsp_ok;
    logic              w_err_set;

    // Scan channels starting at the round-robin pointer; first requester wins.
    always_comb begin
        w_rd_ok    = !spl_reset && !c0_almfull && (r_rd_cnt < 10'(MAX_RD_OUT));
        w_rd_found = 1'b0;
        w_idx      = '0;
        w_gnt_idx  = '0;
        w_gnt      = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_idx = CH_W'((32'(r_rr_ptr) + k) % NUM_CH);
            if (!w_rd_found && cor_rd_valid[w_idx]) begin
                w_rd_found = 1'b1;
                w_gnt_idx  = w_idx;
            end
        end
        w_rd_acc = w_rd_ok && w_rd_found;
        if (w_rd_acc) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_rsp_ch    = spl_rx_rd_mdata[15:8];
        w_rsp_ok    = spl_rx_rd_valid && (32'(w_rsp_ch) < NUM_CH) && (r_rd_cnt != '0);
        w_rsp_oh    = NUM_CH'(1) << w_rsp_ch;
        w_wr_rdy    = !spl_reset && !c1_almfull && (r_wr_cnt < 10'(MAX_WR_OUT))
                      && !((FENCE_BLOCK != 0) && r_fence_pend);
        w_wr_acc    = cor_wr_valid && w_wr_rdy;
        w_wr_line   = w_wr_acc && !cor_wr_fence;
        w_wr_fnc    = w_wr_acc && cor_wr_fence;
        w_wrsp_fnc  = spl_rx_wr_valid && spl_rx_wr_fence;
        w_wrsp_line = spl_rx_wr_valid && !spl_rx_wr_fence;
        w_wrsp_ok   = w_wrsp_line && (r_wr_cnt != '0);
        w_err_set   = (spl_rx_rd_valid && !w_rsp_ok) || (w_wrsp_fnc && !r_fence_pend)
                      || (w_wrsp_line && (r_wr_cnt == '0));
    end

    always_ff @(posedge clk or posedge spl_reset) begin
        if (spl_reset) begin
            r_rr_ptr      <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_seq[i] <= '0;
            end
            r_tx_rd_valid <= 1'b0;
            r_tx_rd_addr  <= '0;
            r_tx_rd_mdata <= '0;
            r_rd_cnt      <= '0;
        end else begin
            r_tx_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_tx_rd_addr     <= cor_rd_addr[w_gnt_idx*ADDR_W +: ADDR_W];
                r_tx_rd_mdata    <= {8'(w_gnt_idx), r_seq[w_gnt_idx]};
                r_seq[w_gnt_idx] <= r_seq[w_gnt_idx] + 8'd1;
                r_rr_ptr         <= (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            r_rd_cnt <= r_rd_cnt + 10'(w_rd_acc) - 10'(w_rsp_ok);
        end
    end

    always_ff @(posedge clk or posedge spl_reset) begin
        if (spl_reset) begin
            r_rx_rd_valid <= '0;
            r_rx_tag      <= '0;
            r_rx_data     <= '0;
        end else begin
            r_rx_rd_valid <= w_rsp_ok ? w_rsp_oh : '0;
            if (w_rsp_ok) begin
                r_rx_tag  <= spl_rx_rd_mdata[7:0];
                r_rx_data <= spl_rx_data;
            end
        end
    end

    always_ff @(posedge clk or posedge spl_reset) begin
        if (spl_reset) begin
            r_tx_wr_valid <= 1'b0;
            r_tx_wr_fence <= 1'b0;
            r_tx_wr_addr  <= '0;
            r_tx_wr_mdata <= '0;
            r_tx_data     <= '0;
            r_wr_cnt      <= '0;
            r_fence_pend  <= 1'b0;
            r_wr_rx_valid <= 1'b0;
            r_wr_rx_tag   <= '0;
            r_err         <= 1'b0;
        end else begin
            r_tx_wr_valid <= w_wr_acc;
            if (w_wr_acc) begin
                r_tx_wr_fence <= cor_wr_fence;
                r_tx_wr_addr  <= cor_wr_fence ? '0 : cor_wr_addr;
                r_tx_wr_mdata <= cor_wr_fence ? '0 : cor_wr_tag;
                r_tx_data     <= cor_wr_data;
            end
            r_wr_cnt <= r_wr_cnt + 10'(w_wr_line) - 10'(w_wrsp_ok);
            // A newly issued fence outranks a completion landing in the same cycle.
            if (w_wr_fnc) begin
                r_fence_pend <= 1'b1;
            end else if (w_wrsp_fnc) begin
                r_fence_pend <= 1'b0;
            end
            r_wr_rx_valid <= w_wrsp_ok;
            if (w_wrsp_ok) begin
                r_wr_rx_tag <= spl_rx_wr_mdata;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cor_rd_ready    = w_gnt;
    assign cor_wr_ready    = w_wr_rdy;
    assign afu_tx_rd_valid = r_tx_rd_valid;
    assign afu_tx_rd_addr  = r_tx_rd_addr;
    assign afu_tx_rd_mdata = r_tx_rd_mdata;
    assign afu_tx_wr_valid = r_tx_wr_valid;
    assign afu_tx_wr_fence = r_tx_wr_fence;
    assign afu_tx_wr_addr  = r_tx_wr_addr;
    assign afu_tx_wr_mdata = r_tx_wr_mdata;
    assign afu_tx_data     = r_tx_data;
    assign io_rx_rd_valid  = r_rx_rd_valid;
    assign io_rx_tag       = r_rx_tag;
    assign io_rx_data      = r_rx_data;
    assign wr_rx_valid     = r_wr_rx_valid;
    assign wr_rx_tag       = r_wr_rx_tag;
    assign rd_out_cnt      = r_rd_cnt;
    assign wr_out_cnt      = r_wr_cnt;
    assign fence_pending   = r_fence_pend;
    assign err_unexp_rsp   = r_err;

endmodule

// File: doc/afu_io_mc.md
Name: afu_io_mc

Overview:
Parametrised multi-channel successor to the single-channel CCI-P I/O adapter. It arbitrates N core read channels round-robin onto the CCI-P c0 TX read port. It forwards one core write/fence stream to the c1 TX port. Each read request carries a channel ID and sequence tag in mdata, and read responses are routed back to the issuing channel by that ID. Outstanding-request counters and c0/c1 almost-full apply back-pressure, and an optional mode blocks writes behind an in-flight write fence.

Parameters:
NUM_CH, 4, number of core read channels (1..16)
ADDR_W, 42, cache-line address width
DATA_W, 512, cache-line data width
MAX_RD_OUT, 64, max outstanding reads, all channels combined (1..1023)
MAX_WR_OUT, 64, max outstanding writes, fences excluded (1..1023)
FENCE_BLOCK, 1, 1 = no write accepted while a fence response is pending

Ports:
clk  in  1  clock
spl_reset  in  1  asynchronous active-high reset
cor_rd_valid  in  NUM_CH  per-channel read request
cor_rd_addr  in  NUM_CH*ADDR_W  per-channel address; channel i at [i*ADDR_W +: ADDR_W]
cor_rd_ready  out  NUM_CH  one-hot grant; request accepted when valid&ready
cor_wr_valid  in  1  write or fence request
cor_wr_fence  in  1  qualifies cor_wr_valid as fence
cor_wr_addr  in  ADDR_W  write address
cor_wr_data  in  DATA_W  write data
cor_wr_tag  in  16  write mdata, passed through
cor_wr_ready  out  1  write accept
c0_almfull  in  1  platform c0 TX almost full
c1_almfull  in  1  platform c1 TX almost full
afu_tx_rd_valid  out  1  read request to platform
afu_tx_rd_addr  out  ADDR_W  read address
afu_tx_rd_mdata  out  16  {channel[7:0], seq[7:0]}
afu_tx_wr_valid  out  1  write request to platform
afu_tx_wr_fence  out  1  1 = WRFENCE, 0 = WRLINE_I
afu_tx_wr_addr  out  ADDR_W  write address (0 for fence)
afu_tx_wr_mdata  out  16  write mdata (0 for fence)
afu_tx_data  out  DATA_W  write data
spl_rx_rd_valid  in  1  read response
spl_rx_rd_mdata  in  16  read response mdata
spl_rx_data  in  DATA_W  read response data
spl_rx_wr_valid  in  1  write response
spl_rx_wr_fence  in  1  write response is a fence completion
spl_rx_wr_mdata  in  16  write response mdata
io_rx_rd_valid  out  NUM_CH  one-hot routed read response
io_rx_tag  out  8  seq field of the response
io_rx_data  out  DATA_W  response data, shared by all channels
wr_rx_valid  out  1  write completion to core
wr_rx_tag  out  16  write completion mdata
rd_out_cnt  out  10  outstanding reads
wr_out_cnt  out  10  outstanding writes
fence_pending  out  1  fence issued, response not yet returned
err_unexp_rsp  out  1  sticky: unroutable or unexpected response

Behaviour:
- Reset (async assert, sync release): every output and counter is 0. Round-robin pointer and all seq counters are 0.
- Read grant (combinational from registered state):
  - cor_rd_ready[i]=1 for the first requesting channel at or after rr_ptr (wrapping).
  - Grant only if !c0_almfull and rd_out_cnt < MAX_RD_OUT.
  - At most one bit of cor_rd_ready is set.
- Read accept:
  - Registered; afu_tx_rd_valid is high the cycle after accept.
  - mdata = {i, seq[i]}; seq[i] then increments and wraps 255 to 0.
  - rr_ptr becomes i+1 mod NUM_CH.
  - afu_tx_rd_valid is low in any cycle with no accept.
- Write ready = !c1_almfull && wr_out_cnt < MAX_WR_OUT && !(FENCE_BLOCK && fence_pending).
- Write accept:
  - Registered, 1-cycle latency, same as reads.
  - Fence: afu_tx_wr_fence=1, addr=0, mdata=0; sets fence_pending; wr_out_cnt unchanged.
  - Non-fence: wr_out_cnt increments.
  - With FENCE_BLOCK=0, fences still set fence_pending, but writes are not blocked.
- Read response:
  - Registered, 1 cycle.
  - Channel = mdata[15:8]. If channel < NUM_CH and rd_out_cnt > 0: io_rx_rd_valid[channel]=1, and io_rx_tag/io_rx_data are updated.
  - Otherwise: no valid asserted, err_unexp_rsp set, counter unchanged.
- Write response:
  - spl_rx_wr_fence=1: clears fence_pending and is not forwarded. If fence_pending is already 0, set err_unexp_rsp.
  - Otherwise: wr_rx_valid/wr_rx_tag registered 1 cycle, and wr_out_cnt decrements. If the count is 0, set the error and do not decrement.
- Same-cycle accept and response: counter is net unchanged.
- Fence accept and fence response in the same cycle: fence_pending stays 1, because the new fence is still pending.
- err_unexp_rsp clears only on reset.
- almfull rising between grant evaluation and accept cannot occur, because ready is combinational on the current almfull.

Test Plan:
- All 4 channels request continuously with random response delay → grants cycle ch0,1,2,3,0…; mdata high bytes 0,1,2,3; each channel's seq runs 0..255 then 0; every response goes to the correct channel.
- MAX_RD_OUT=4, no responses → ready drops after the 4th accept and rd_out_cnt=4. One response → exactly one more accept.
- c0_almfull=1 while requests pending → cor_rd_ready=0 and afu_tx_rd_valid=0 until almfull drops. Same check for c1_almfull on writes.
- Write A (tag 0x11), fence, write B, with FENCE_BLOCK=1 → A issued, fence issued (addr 0, mdata 0), B held until fence response arrives, then B issued. With FENCE_BLOCK=0, B issues the cycle after the fence.
- Read response with mdata 0x0500 at NUM_CH=4, a fence response with none pending, and a write response at wr_out_cnt=0 → no io_rx_rd_valid or wr_rx_valid, err_unexp_rsp=1, counters unchanged.
- Assert spl_reset mid-traffic with 3 reads outstanding → all outputs 0 immediately (async). After release, rd_out_cnt=0, seq counters restart at 0, and the first grant is ch0.
